// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl_if
// Description : Operand/result bundle for the nibble-serial add/sub sequencer.
//               The slave side is the sequencer; the master side is the
//               operand source and result consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int c_W    = 4 * NIBBLES;
    localparam int c_IDXW = $clog2(NIBBLES);

    logic              start;
    logic              sub;
    logic [c_W-1:0]    a;
    logic [c_W-1:0]    b;
    logic [c_W-1:0]    sum;
    logic              cout;
    logic              overflow;
    logic              busy;
    logic              done;
    logic [c_IDXW-1:0] nib_idx;

    modport master (
        output start, sub, a, b,
        input  sum, cout, overflow, busy, done, nib_idx
    );

    modport slave (
        input  start, sub, a, b,
        output sum, cout, overflow, busy, done, nib_idx
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Multi-nibble add/subtract built from one time-shared 4-bit
//               ripple-carry slice, LS nibble first, carry registered between
//               nibbles. Result and flags are held until the next operation.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int                c_W    = 4 * NIBBLES;
    localparam int                c_IDXW = $clog2(NIBBLES);
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_W-1:0]    r_a;
    logic [c_W-1:0]    r_b;
    logic              r_sub;
    logic              r_carry;
    logic [c_W-1:0]    r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_busy;
    logic              r_done;
    logic [c_IDXW-1:0] r_idx;

    logic [3:0]        w_x;
    logic [3:0]        w_y;
    logic [3:0]        w_s;
    logic [4:0]        w_c;

    // Shared 4-bit slice: operand nibbles selected by the current index,
    // B inverted for subtraction (the +1 enters through the initial carry).
    always_comb begin
        w_x = r_a[4*r_idx +: 4];
        w_y = r_b[4*r_idx +: 4] ^ {4{r_sub}};
        w_s = '0;
        w_c = '0;
        w_c[0] = r_carry;
        for (int j = 0; j < 4; j++) begin
            w_s[j]   = w_x[j] ^ w_y[j] ^ w_c[j];
            w_c[j+1] = (w_x[j] & w_y[j]) | (w_x[j] & w_c[j]) | (w_y[j] & w_c[j]);
        end
    end

    // Sequencer: latch operands on start, walk the nibbles, pulse done once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_sub   <= bus.sub;
                        r_carry <= bus.sub;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum[4*r_idx +: 4] <= w_s;
                    r_carry             <= w_c[4];
                    if (r_idx == c_LAST) begin
                        // Signed overflow: carry into the sign bit differs from carry out.
                        r_cout  <= w_c[4];
                        r_ovf   <= w_c[3] ^ w_c[4];
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.nib_idx  = r_idx;
endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that time-shares one 4-bit ripple-carry full-adder slice to perform multi-nibble add/subtract. Operands are latched on a start handshake. The slice is applied least-significant nibble first, one nibble per clock, with the carry registered between nibbles. The result is held with status flags. It sits between switch/operand registers and LED/HEX display logic on the board top level.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled on the rising edge
sub  input  1  0 = A+B, 1 = A-B; sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
sum  output  W  result register
cout  output  1  carry out of the MSB (subtract: 1 = no borrow)
overflow  output  1  two's-complement signed overflow
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when the result is valid
nib_idx  output  clog2(NIBBLES)  index of the nibble being processed (debug/LED)

Behaviour:
- Reset (async, any time including mid-operation) forces:
  - state=IDLE; sum=0, cout=0, overflow=0, busy=0, done=0, nib_idx=0.
  - Internal operand, carry and mode registers cleared.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0; outputs hold the last result.
  - Edge with start=1: latch a, b and sub into internal registers.
  - carry_reg <= sub; nib_idx <= 0; state <= RUN.
- RUN: busy=1. Slice inputs per cycle:
  - x = A_reg[4i+3:4i]
  - y = B_reg nibble i, or its bitwise complement when sub_reg=1
  - cin = carry_reg, where i = nib_idx
- RUN, each edge:
  - sum[4i+3:4i] <= slice sum; carry_reg <= slice cout; nib_idx <= i+1.
  - If i == NIBBLES-1: cout <= slice cout; overflow <= (carry into bit 3 of slice) XOR (slice cout); nib_idx <= 0; state <= DONE.
- DONE: done=1, busy=0, for exactly one cycle.
  - Next edge: start=1 is accepted exactly as in IDLE (back-to-back); otherwise state <= IDLE.
- start in RUN is ignored. Operand or sub changes during RUN have no effect, because the latched copies are used.
- Latency: start sampled at edge k; busy high for cycles k+1 .. k+NIBBLES; done high in cycle k+NIBBLES+1.
- sum upper nibbles are updated progressively during RUN. Upper nibbles hold stale values from the previous result until overwritten. sum is only architecturally valid while done=1 and afterwards until the next accepted start.
- cout and overflow keep their previous values until the final RUN edge.
- Arithmetic is modulo 2^W; there is no saturation.
- The slice is combinational: 4 chained full adders, sum = x^y^c, carry = majority.

Test Plan:
- Reset mid-RUN (Reset=1 two cycles after start): all outputs 0 immediately, state IDLE. After Reset=0, a new start completes normally.
- NIBBLES=4, a=0x1234, b=0x0FCD, sub=0, start 1 cycle: done pulses exactly 5 cycles after the start edge with sum=0x2201, cout=0, overflow=0. busy high for 4 cycles. nib_idx steps 0,1,2,3.
- a=0xFFFF, b=0x0001, sub=0: sum=0x0000, cout=1, overflow=0. Carry propagates through all 4 nibbles.
- a=0x7FFF, b=0x0001, sub=0: sum=0x8000, cout=0, overflow=1. Then a=0x0005, b=0x0007, sub=1: sum=0xFFFE, cout=0 (borrow), overflow=0.
- Hold start=1 continuously with a=0x0001, b=0x0001: back-to-back operations. done pulses every 5 cycles, sum=0x0002. start pulses during RUN are ignored; done pulse count equals accepted starts.
- Change a, b and sub during RUN (a=0x1111, b=0x2222 latched, then inputs driven to 0xFFFF): result is still 0x3333, cout=0, overflow=0.
